// File: rtl/mem_block_responder_if.sv
// Block-level request/response bundle between the cache controller (master)
// and the main-memory responder (slave).
interface mem_block_responder_if #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_DATA_WIDTH = 512
);
  logic                        mem_req_enable;
  logic                        mem_req_rw;
  logic [WORD_SIZE-1:0]        mem_req_addr;
  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout;
  logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain;
  logic                        mem_req_ready;
  logic                        mem_busy;
  logic                        mem_err;

  modport master (
    output mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout,
    input  mem_req_datain, mem_req_ready, mem_busy, mem_err
  );

  modport slave (
    input  mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout,
    output mem_req_datain, mem_req_ready, mem_busy, mem_err
  );
endinterface

// File: rtl/mem_block_responder.sv
// Main-memory block responder: one request at a time, fixed read/write latency.
// Optional MEM_RESP_STATS_EN adds saturating in-range read/write counters.
//
// state   | meaning
// IDLE    | waiting for mem_req_enable
// WAIT    | latency down-counter running; array accessed on the exit edge
// RESPOND | mem_req_ready / mem_err valid for this single cycle
module mem_block_responder #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_DATA_WIDTH = 512,
  parameter int BLOCK_OFFSET     = 4,
  parameter int MEM_BLOCKS_BITS  = 8,
  parameter int READ_LATENCY     = 4,
  parameter int WRITE_LATENCY    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_block_responder_if.slave   bus
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
`endif
);

  localparam int IDX_LO  = BLOCK_OFFSET + 2;
  localparam int IDX_HI  = IDX_LO + MEM_BLOCKS_BITS;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic                        req_rw;
  logic                        req_oor;
  logic [MEM_BLOCKS_BITS-1:0]  req_idx;
  logic [BLOCK_DATA_WIDTH-1:0] req_wdata;
  logic                        addr_oor;
  logic                        access_now;
  logic                        unused_addr_lo;

  logic [BLOCK_DATA_WIDTH-1:0] mem [2**MEM_BLOCKS_BITS];

  assign addr_oor       = (bus.mem_req_addr >> IDX_HI) != '0;
  assign access_now     = (state == WAIT) && (cnt == '0);
  assign unused_addr_lo = ^bus.mem_req_addr[IDX_LO-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      req_rw             <= 1'b0;
      req_oor            <= 1'b0;
      req_idx            <= '0;
      req_wdata          <= '0;
      bus.mem_req_datain <= '0;
      bus.mem_req_ready  <= 1'b0;
      bus.mem_busy       <= 1'b0;
      bus.mem_err        <= 1'b0;
    end else begin
      bus.mem_req_ready <= 1'b0;
      bus.mem_err       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_req_enable) begin
            req_rw       <= bus.mem_req_rw;
            req_idx      <= bus.mem_req_addr[IDX_LO +: MEM_BLOCKS_BITS];
            req_oor      <= addr_oor;
            req_wdata    <= bus.mem_req_dataout;
            cnt          <= bus.mem_req_rw ? CNT_W'(WRITE_LATENCY - 1)
                                           : CNT_W'(READ_LATENCY - 1);
            bus.mem_busy <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state             <= RESPOND;
            bus.mem_req_ready <= 1'b1;
            bus.mem_err       <= req_oor;
            if (!req_rw)
              bus.mem_req_datain <= req_oor ? '0 : mem[req_idx];
          end
        end
        RESPOND: begin
          bus.mem_busy <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Contents are deliberately not reset; reset forces IDLE, which drops any in-flight write.
  always_ff @(posedge clk) begin
    if (access_now && req_rw && !req_oor)
      mem[req_idx] <= req_wdata;
  end

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == RESPOND && !req_oor) begin
      if (req_rw) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
// Self-checking bench for mem_block_responder: vector table, corner-case
// sequences and a randomized phase against a block-level reference model.
module tb_mem_block_responder;
  localparam int WS  = 32;
  localparam int BDW = 512;
  localparam int RL  = 4;
  localparam int WL  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_block_responder_if #(.WORD_SIZE(WS), .BLOCK_DATA_WIDTH(BDW)) bus ();
`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  mem_block_responder #(
    .WORD_SIZE(WS), .BLOCK_DATA_WIDTH(BDW), .BLOCK_OFFSET(4),
    .MEM_BLOCKS_BITS(8), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_RESP_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [BDW-1:0] act, logic [BDW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [BDW-1:0] pattern();
    logic [BDW-1:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = 32'hDEADBEEF + 32'(i);
    return b;
  endfunction

  function automatic logic [BDW-1:0] rand_block();
    logic [BDW-1:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // One complete request; checks latency, error flag, busy window, single-cycle
  // ready, and (optionally) the read block both at ready and one cycle later.
  task automatic run_req(input string tag, input bit rw, input logic [31:0] addr,
                         input logic [BDW-1:0] wd, input bit exp_err, input int exp_lat,
                         input bit chk_data, input logic [BDW-1:0] exp_data);
    int lat;
    int busy_cyc;
    bit err;
    logic [BDW-1:0] d_rdy;
    @(negedge clk);
    bus.mem_req_enable  = 1'b1;
    bus.mem_req_rw      = rw;
    bus.mem_req_addr    = addr;
    bus.mem_req_dataout = wd;
    @(posedge clk); #1;
    bus.mem_req_enable  = 1'b0;
    bus.mem_req_addr    = addr ^ 32'h0000_0040;
    bus.mem_req_dataout = ~wd;
    busy_cyc = bus.mem_busy ? 1 : 0;
    lat = 0;
    err = 1'b0;
    d_rdy = '0;
    for (int c = 1; c <= 16 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (bus.mem_busy) busy_cyc++;
      if (bus.mem_req_ready) begin
        lat   = c;
        err   = bus.mem_err;
        d_rdy = bus.mem_req_datain;
      end
    end
    chk({tag, " latency"}, BDW'(lat), BDW'(exp_lat));
    chk({tag, " err"}, BDW'(err), BDW'(exp_err));
    chk({tag, " busy cycles"}, BDW'(busy_cyc), BDW'(exp_lat + 1));
    @(posedge clk); #1;
    chk({tag, " ready fall"}, BDW'(bus.mem_req_ready), '0);
    chk({tag, " busy fall"}, BDW'(bus.mem_busy), '0);
    if (chk_data) begin
      chk({tag, " datain at ready"}, d_rdy, exp_data);
      chk({tag, " datain held"}, bus.mem_req_datain, exp_data);
    end
  endtask

  typedef struct {
    string          name;
    bit             rw;
    logic [31:0]    addr;
    logic [BDW-1:0] wdata;
    bit             exp_err;
    int             exp_lat;
    logic [BDW-1:0] exp_datain;
  } vec_t;

  vec_t vecs[6];

  logic [BDW-1:0] model [16];
  logic [BDW-1:0] last_rd;
  int             exp_rd, exp_wr;

  initial begin
    logic [BDW-1:0] pat;
    int pulses, first;
    pat = pattern();

    vecs[0] = '{"wr 0x40",        1'b1, 32'h0000_0040, pat,  1'b0, WL, '0};
    vecs[1] = '{"rd 0x40",        1'b0, 32'h0000_0040, '0,   1'b0, RL, pat};
    vecs[2] = '{"rd 0x7C",        1'b0, 32'h0000_007C, '0,   1'b0, RL, pat};
    vecs[3] = '{"rd 0x4000 oor",  1'b0, 32'h0000_4000, '0,   1'b1, RL, '0};
    vecs[4] = '{"wr 0x4040 oor",  1'b1, 32'h0000_4040, ~pat, 1'b1, WL, '0};
    vecs[5] = '{"rd 0x40 again",  1'b0, 32'h0000_0040, '0,   1'b0, RL, pat};

    rst_n = 1'b0;
    bus.mem_req_enable  = 1'b0;
    bus.mem_req_rw      = 1'b0;
    bus.mem_req_addr    = '0;
    bus.mem_req_dataout = '0;
    #12;
    chk("reset ready", BDW'(bus.mem_req_ready), '0);
    chk("reset busy", BDW'(bus.mem_busy), '0);
    chk("reset err", BDW'(bus.mem_err), '0);
    chk("reset datain", bus.mem_req_datain, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_req(vecs[i].name, vecs[i].rw, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_err, vecs[i].exp_lat, 1'b1, vecs[i].exp_datain);

    // Enable pulse during a read's WAIT must be dropped, not queued.
    @(negedge clk);
    bus.mem_req_enable = 1'b1; bus.mem_req_rw = 1'b0; bus.mem_req_addr = 32'h0000_007C;
    @(posedge clk); #1;
    bus.mem_req_enable = 1'b0;
    @(negedge clk);
    bus.mem_req_enable = 1'b1; bus.mem_req_rw = 1'b1; bus.mem_req_addr = 32'h0000_0040;
    bus.mem_req_dataout = '0;
    @(posedge clk); #1;
    bus.mem_req_enable = 1'b0;
    pulses = 0;
    first  = 0;
    for (int c = 2; c <= 14; c++) begin
      @(posedge clk); #1;
      if (bus.mem_req_ready) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    chk("ignored enable pulses", BDW'(pulses), BDW'(1));
    chk("ignored enable latency", BDW'(first), BDW'(RL));
    chk("ignored enable datain", bus.mem_req_datain, pat);
    run_req("rd 0x40 after ignored wr", 1'b0, 32'h0000_0040, '0, 1'b0, RL, 1'b1, pat);

    // Reset one cycle into a write's WAIT: write discarded, outputs cleared.
    @(negedge clk);
    bus.mem_req_enable = 1'b1; bus.mem_req_rw = 1'b1; bus.mem_req_addr = 32'h0000_0040;
    bus.mem_req_dataout = '0;
    @(posedge clk); #1;
    bus.mem_req_enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset ready", BDW'(bus.mem_req_ready), '0);
    chk("midreset busy", BDW'(bus.mem_busy), '0);
    chk("midreset err", BDW'(bus.mem_err), '0);
    chk("midreset datain", bus.mem_req_datain, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.mem_req_ready) pulses++;
    end
    chk("no ready after reset", BDW'(pulses), '0);
    run_req("rd 0x40 after reset", 1'b0, 32'h0000_0040, '0, 1'b0, RL, 1'b1, pat);
    exp_rd = 1;
    exp_wr = 0;
`ifdef MEM_RESP_STATS_EN
    chk("rd_count after reset read", BDW'(rd_count), BDW'(1));
    chk("wr_count after reset read", BDW'(wr_count), BDW'(0));
`endif
    last_rd = pat;

    // Randomized phase: 16 blocks at block numbers 17*k, plus out-of-range traffic.
    for (int k = 0; k < 16; k++) begin
      model[k] = rand_block();
      run_req("rand prewrite", 1'b1, 32'(k * 17 * 64), model[k], 1'b0, WL, 1'b1, last_rd);
      exp_wr++;
    end
    for (int n = 0; n < 40; n++) begin
      logic [31:0] addr;
      logic [BDW-1:0] wd, exp_d;
      bit rw, oor;
      int k;
      rw = $urandom_range(0, 1) == 1;
      wd = rand_block();
      k  = $urandom_range(0, 15);
      if ($urandom_range(0, 4) == 0)
        addr = ($urandom_range(1, 262143) << 14) | ($urandom & 32'h0000_3FFF);
      else
        addr = 32'(k * 17 * 64) + 32'($urandom_range(0, 63));
      oor = addr >= 32'h0000_4000;
      if (rw) begin
        if (!oor) begin
          model[k] = wd;
          exp_wr++;
        end
        exp_d = last_rd;
      end else begin
        exp_d = oor ? '0 : model[k];
        if (!oor) exp_rd++;
        last_rd = exp_d;
      end
      run_req(rw ? "rand wr" : "rand rd", rw, addr, wd, oor, rw ? WL : RL, 1'b1, exp_d);
    end
`ifdef MEM_RESP_STATS_EN
    chk("rd_count final", BDW'(rd_count), BDW'(exp_rd));
    chk("wr_count final", BDW'(wr_count), BDW'(exp_wr));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
